dmem_arbiter: RTL and testbench

Sequences the single-ported data memory behind the pipeline's MEM stage and shares it between two requesters: the CPU MEM stage and an external loader/debug port.
Handles a fixed-latency memory with a 4-state FSM. Stalls the pipeline while a CPU access is in flight. Gives the CPU priority, with a starvation bound for the external port.
Sits between the EX/MEM register outputs and the data memory, alongside the MEM forwarding logic.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_arb_select.sv | 26 ++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and transaction owner.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_EXT = 1'b1;

endpackage

// File: rtl/dmem_arb_select.sv
// Grant decision: CPU wins ties unless it has starved the external port for STARVE_MAX grants.
module dmem_arb_select
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int STREAK_W   = $clog2(STARVE_MAX + 1)
) (
    input  logic                cpu_req,
    input  logic                ext_req,
    input  logic [STREAK_W-1:0] cpu_streak,
    output logic                grant_valid,
    output logic                grant_owner
);

    logic starved;

    always_comb begin
        starved     = (cpu_streak >= STREAK_W'(STARVE_MAX));
        grant_valid = cpu_req | ext_req;
        grant_owner = OWNER_CPU;
        if (ext_req && (!cpu_req || starved)) begin
            grant_owner = OWNER_EXT;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a fixed-latency single-port data memory between the MEM stage and an external port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic              o_ext_ack,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam int CNT_W    = $clog2(MEM_LAT + 1);

    logic [1:0]          state;
    logic                owner;
    logic                we_lat;
    logic [CNT_W-1:0]    count;
    logic [STREAK_W-1:0] cpu_streak;
    logic                grant_valid;
    logic                grant_owner;

    dmem_arb_select #(
        .STARVE_MAX (STARVE_MAX),
        .STREAK_W   (STREAK_W)
    ) u_select (
        .cpu_req     (i_cpu_req),
        .ext_req     (i_ext_req),
        .cpu_streak  (cpu_streak),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The stall drops in the CPU's own RESP cycle so the pipeline advances exactly once.
    assign o_cpu_stall = !i_rst && i_cpu_req && !(state == ST_RESP && owner == OWNER_CPU);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            owner       <= OWNER_CPU;
            we_lat      <= 1'b0;
            count       <= '0;
            cpu_streak  <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_cpu_rdata <= '0;
            o_ext_rdata <= '0;
            o_ext_ack   <= 1'b0;
        end else begin
            o_mem_en  <= 1'b0;
            o_mem_we  <= 1'b0;
            o_ext_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_owner;
                        o_mem_en <= 1'b1;
                        state    <= ST_ISSUE;
                        if (grant_owner == OWNER_EXT) begin
                            we_lat      <= i_ext_we;
                            o_mem_we    <= i_ext_we;
                            o_mem_addr  <= i_ext_addr;
                            o_mem_wdata <= i_ext_wdata;
                            cpu_streak  <= '0;
                        end else begin
                            we_lat      <= i_cpu_we;
                            o_mem_we    <= i_cpu_we;
                            o_mem_addr  <= i_cpu_addr;
                            o_mem_wdata <= i_cpu_wdata;
                            if (!i_ext_req) begin
                                cpu_streak <= '0;
                            end else if (cpu_streak < STREAK_W'(STARVE_MAX)) begin
                                cpu_streak <= cpu_streak + 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (we_lat) begin
                        state     <= ST_RESP;
                        o_ext_ack <= (owner == OWNER_EXT);
                    end else begin
                        state <= ST_WAIT;
                        count <= CNT_W'(MEM_LAT);
                    end
                end
                ST_WAIT: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state     <= ST_RESP;
                        o_ext_ack <= (owner == OWNER_EXT);
                        if (owner == OWNER_EXT) begin
                            o_ext_rdata <= i_mem_rdata;
                        end else begin
                            o_cpu_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with MEM_LAT=2, STARVE_MAX=4.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rd_mode;
    logic [31:0] rd_val;

    int checks   = 0;
    int failures = 0;
    int cpu_done;
    int ack_cnt;

    always #5 clk = ~clk;

    // Memory model: address-tagged data, or a directly driven word when rd_mode is set.
    assign mem_rdata = rd_mode ? rd_val : {16'hC0DE, mem_addr[15:0]};

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_stall (cpu_stall),
        .i_ext_req   (ext_req),
        .i_ext_we    (ext_we),
        .i_ext_addr  (ext_addr),
        .i_ext_wdata (ext_wdata),
        .o_ext_ack   (ext_ack),
        .o_ext_rdata (ext_rdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        rd_mode = 1'b0; rd_val = '0;
        next_cycle();
        next_cycle();
        #1;
        check("rst_stall", cpu_stall, 0);
        check("rst_state", dut.state, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_ext_ack", ext_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_streak", dut.cpu_streak, 0);
        rst = 1'b0; cpu_req = 1'b0;

        // Test 1: CPU load of 0x10
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        rd_mode = 1'b1; rd_val = 32'h1111_1111;
        #1;
        check("t1_c0_stall", cpu_stall, 1);
        check("t1_c0_mem_en", mem_en, 0);
        next_cycle(); #1;
        check("t1_c1_mem_en", mem_en, 1);
        check("t1_c1_mem_we", mem_we, 0);
        check("t1_c1_addr", mem_addr, 32'h10);
        check("t1_c1_stall", cpu_stall, 1);
        next_cycle(); #1;
        check("t1_c2_mem_en", mem_en, 0);
        check("t1_c2_stall", cpu_stall, 1);
        next_cycle();
        rd_val = 32'hDEAD_BEEF;
        #1;
        check("t1_c3_stall", cpu_stall, 1);
        check("t1_c3_rdata", cpu_rdata, 0);
        next_cycle();
        rd_val = 32'h2222_2222;
        #1;
        check("t1_c4_stall", cpu_stall, 0);
        check("t1_c4_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 1'b0;
        next_cycle(); #1;
        check("t1_c5_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
        check("t1_c5_state", dut.state, 0);

        // Test 2: CPU store 0x1234 to 0x20
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
        #1;
        check("t2_c0_stall", cpu_stall, 1);
        next_cycle(); #1;
        check("t2_c1_mem_en", mem_en, 1);
        check("t2_c1_mem_we", mem_we, 1);
        check("t2_c1_addr", mem_addr, 32'h20);
        check("t2_c1_wdata", mem_wdata, 32'h1234);
        next_cycle(); #1;
        check("t2_c2_stall", cpu_stall, 0);
        check("t2_c2_mem_we", mem_we, 0);
        check("t2_c2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 1'b0; cpu_we = 1'b0;
        next_cycle(); #1;
        check("t2_c3_state", dut.state, 0);

        // Test 3: simultaneous CPU and ext reads; CPU wins
        rd_mode = 1'b0;
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h30;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
        next_cycle(); #1;
        check("t3_c1_addr", mem_addr, 32'h30);
        check("t3_c1_streak", dut.cpu_streak, 1);
        next_cycle();
        next_cycle();
        next_cycle(); #1;
        check("t3_c4_stall", cpu_stall, 0);
        check("t3_c4_cpu_rdata", cpu_rdata, 32'hC0DE_0030);
        cpu_req = 1'b0;
        next_cycle(); #1;
        check("t3_c5_ack", ext_ack, 0);
        check("t3_c5_mem_en", mem_en, 0);
        next_cycle(); #1;
        check("t3_c6_mem_en", mem_en, 1);
        check("t3_c6_addr", mem_addr, 32'h40);
        check("t3_c6_streak", dut.cpu_streak, 0);
        next_cycle(); #1;
        check("t3_c7_ack", ext_ack, 0);
        next_cycle(); #1;
        check("t3_c8_ack", ext_ack, 0);
        next_cycle(); #1;
        check("t3_c9_ack", ext_ack, 1);
        check("t3_c9_ext_rdata", ext_rdata, 32'hC0DE_0040);
        check("t3_c9_cpu_rdata", cpu_rdata, 32'hC0DE_0030);
        ext_req = 1'b0;
        next_cycle(); #1;
        check("t3_c10_ack", ext_ack, 0);

        // Test 4: back-to-back CPU loads while ext read of 0x40 is held
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h50;
        ext_req = 1'b1; ext_addr = 32'h40;
        cpu_done = 0; ack_cnt = 0;
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) next_cycle();
            #1;
            if (cpu_req && !cpu_stall) cpu_done++;
            if (ext_ack) ack_cnt++;
            if (c == 20) check("t4_c20_streak", dut.cpu_streak, 4);
            if (c == 21) begin
                check("t4_c21_mem_en", mem_en, 1);
                check("t4_c21_addr", mem_addr, 32'h40);
                check("t4_c21_streak", dut.cpu_streak, 0);
            end
            if (c == 24) begin
                check("t4_c24_ack", ext_ack, 1);
                cpu_req = 1'b0;
                ext_req = 1'b0;
            end
        end
        check("t4_cpu_done", cpu_done, 4);
        check("t4_ack_cnt", ack_cnt, 1);
        next_cycle(); #1;
        check("t4_end_streak", dut.cpu_streak, 0);
        check("t4_end_state", dut.state, 0);

        // Test 5: reset during WAIT of an ext read, then reissue
        next_cycle();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h60;
        next_cycle(); #1;
        check("t5_c1_mem_en", mem_en, 1);
        next_cycle();
        rst = 1'b1;
        #1;
        check("t5_c2_stall_rst", cpu_stall, 0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("t5_c3_state", dut.state, 0);
        check("t5_c3_mem_en", mem_en, 0);
        check("t5_c3_mem_we", mem_we, 0);
        check("t5_c3_ack", ext_ack, 0);
        check("t5_c3_ext_rdata", ext_rdata, 0);
        ack_cnt = 0;
        for (int c = 4; c <= 6; c++) begin
            next_cycle(); #1;
            if (ext_ack) ack_cnt++;
        end
        check("t5_early_ack", ack_cnt, 0);
        next_cycle(); #1;
        check("t5_c7_ack", ext_ack, 1);
        check("t5_c7_ext_rdata", ext_rdata, 32'hC0DE_0060);
        ext_req = 1'b0;

        // Test 6: ext address changes mid-transaction
        next_cycle();
        ext_req = 1'b1; ext_addr = 32'h40;
        next_cycle(); #1;
        check("t6_c1_addr", mem_addr, 32'h40);
        next_cycle();
        ext_addr = 32'h80;
        next_cycle(); #1;
        check("t6_c3_addr", mem_addr, 32'h40);
        next_cycle(); #1;
        check("t6_c4_ack", ext_ack, 1);
        check("t6_c4_ext_rdata", ext_rdata, 32'hC0DE_0040);
        ext_req = 1'b0;
        next_cycle(); #1;
        check("t6_c5_ack", ext_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
